// File: rtl/quad_step_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Front end of the up/down counter. The raw quadrature channels A and B are
// brought into the clk domain through a flop chain. Each channel is then
// deglitched by a persistence filter. Gray-code transitions of the filtered
// pair are decoded into a one-cycle step pulse and a direction level.
//
// Up sequence of {A,B}: 00 -> 01 -> 11 -> 10 -> 00. The reverse order counts
// down. If both bits change in one decode cycle, the direction cannot be
// known. No step is issued in that case, and the sticky err flag is raised.
//
// After reset release, a short INIT phase lets the synchroniser and filters
// load the current input level without decoding. This means a shaft parked
// at a non-00 position at power-up gives neither a step nor an error.
//
// Parameters
//   SYNC_STAGES  flops per channel in the synchroniser (>= 2)
//   FILT_LEN     cycles a synced level must differ before it is accepted (>= 1)
//   FILT_W       width of the per-channel filter counter, 2**FILT_W > FILT_LEN
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   a_in      raw channel A, asynchronous to clk
//   b_in      raw channel B, asynchronous to clk
//   clr_err   synchronous clear of err (a simultaneous new error wins)
//   step      one-cycle pulse per valid quadrature transition
//   dir       direction of the last valid transition, 1 = up, 0 = down
//   err       sticky illegal-transition flag
//   ab_state  filtered {A,B}
// -----------------------------------------------------------------------------
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int FILT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       clr_err,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic [1:0] ab_state
);

  // INIT covers the time for a level to pass through the synchroniser and
  // the filter path. When INIT ends, prev and filtered already agree.
  localparam int INIT_LEN = SYNC_STAGES + FILT_LEN;
  localparam int INIT_W   = $clog2(INIT_LEN + 1);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [INIT_W-1:0] init_cnt;
  logic [INIT_W-1:0] init_cnt_d;

  // Bit 1 is channel A and bit 0 is channel B, so every vector reads as {A,B}.
  logic [1:0] raw;
  logic [1:0] synced;
  logic [1:0] filtered;
  logic [1:0] prev;

  logic       step_d;
  logic       dir_d;
  logic       err_d;

  logic [1:0] cur_pos;
  logic [1:0] prev_pos;
  logic [1:0] pos_delta;

  assign raw = {a_in, b_in};

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser and persistence filter
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_W-1:0]      filt_cnt;
    logic                   filt_q;

    // NOTE: every flop here, including the synchroniser chain, is reset to 0.
    // A second reset then behaves exactly like power-up, and INIT reloads the
    // real input level afterwards.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q   <= '0;
        filt_cnt <= '0;
        filt_q   <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments make each stage take the value its
        // neighbour held before this edge. That is what forms a real chain.
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};

        if (state == ST_INIT) begin
          // Bypass the filter so the power-up level is taken directly.
          filt_q   <= sync_q[SYNC_STAGES-1];
          filt_cnt <= '0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
          // Any return to the accepted level restarts the count. Pulses
          // shorter than FILT_LEN cycles therefore never get through.
          filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
          filt_q   <= sync_q[SYNC_STAGES-1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FILT_W'(1);
        end
      end
    end

    assign synced[ch]   = sync_q[SYNC_STAGES-1];
    assign filtered[ch] = filt_q;
  end : g_chan

  assign ab_state = filtered;

  // ---------------------------------------------------------------------------
  // Gray-code decode
  // ---------------------------------------------------------------------------
  // Map each Gray code to its position in the up sequence. The difference
  // between positions, taken modulo 4, then classifies the move:
  // 1 = up, 3 = down, 2 = both bits changed, 0 = no change.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign cur_pos   = gray_pos(filtered);
  assign prev_pos  = gray_pos(prev);
  assign pos_delta = cur_pos - prev_pos;

  // ---------------------------------------------------------------------------
  // FSM: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that does
    // not assign a signal then holds it through the defaults rather than
    // through an inferred latch.
    state_d    = state;
    init_cnt_d = init_cnt;
    step_d     = 1'b0;
    dir_d      = dir;
    err_d      = err;

    unique case (state)
      ST_INIT: begin
        init_cnt_d = init_cnt + INIT_W'(1);
        if (init_cnt == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end

      ST_RUN: begin
        // The clear is applied first so that a new error on the same cycle
        // overrides it.
        if (clr_err) begin
          err_d = 1'b0;
        end
        unique case (pos_delta)
          2'd1: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
          end
          2'd3: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
          end
          2'd2: begin
            err_d = 1'b1;
          end
          default: begin
          end
        endcase
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      prev     <= 2'b00;
      step     <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      init_cnt <= init_cnt_d;
      // prev follows filtered in both states, so the first RUN decode
      // compares two equal values when the input is steady.
      prev     <= filtered;
      step     <= step_d;
      dir      <= dir_d;
      err      <= err_d;
    end
  end

  // The synced pair is consumed only through the filters. It is exposed as a
  // vector here so the two channels are easy to probe together.
  logic unused_synced;
  assign unused_synced = ^synced;

endmodule : quad_step_decoder

// File: tb/tb_quad_step_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_quad_step_decoder
//
// Scoreboard bench for quad_step_decoder with the default parameters.
//
// Each time the stimulus moves the clean {A,B} level, the expected responses
// are pushed into queues. Each response is tagged with the cycle it is due:
//   - step and dir, from the position change in the up sequence;
//   - a rise of err, for a double-bit change;
//   - the new ab_state value.
// A monitor on the falling edge pops and compares these responses. Glitches
// push nothing, because they must not produce any response.
// -----------------------------------------------------------------------------
module tb_quad_step_decoder;

  localparam int SYNC = 2;
  localparam int FLEN = 3;
  localparam int LAT  = SYNC + FLEN + 1;  // raw change -> step / err
  localparam int ALAT = SYNC + FLEN;      // raw change -> ab_state

  logic       clk;
  logic       rst;
  logic       a_in;
  logic       b_in;
  logic       clr_err;
  logic       step;
  logic       dir;
  logic       err;
  logic [1:0] ab_state;

  quad_step_decoder #(
    .SYNC_STAGES(SYNC),
    .FILT_LEN   (FLEN),
    .FILT_W     (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .clr_err (clr_err),
    .step    (step),
    .dir     (dir),
    .err     (err),
    .ab_state(ab_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [1:0] val;
  } ev_t;

  ev_t step_q[$];
  ev_t err_q[$];
  ev_t ab_q[$];

  int         errors = 0;
  int         checks = 0;
  logic [1:0] cur_lvl;
  logic       err_final;     // err level once all queued events have occurred
  int         last_ill_due;
  logic       err_exp;
  logic       dir_exp;
  logic [1:0] ab_exp;
  bit         chk_ab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Position of a level in the up sequence 00,01,11,10.
  function automatic int seq_idx(input logic [1:0] l);
    logic [1:0] up_seq [4];
    up_seq[0] = 2'b00; up_seq[1] = 2'b01; up_seq[2] = 2'b11; up_seq[3] = 2'b10;
    for (int i = 0; i < 4; i++) if (up_seq[i] == l) return i;
    return 0;
  endfunction

  function automatic logic [1:0] seq_lvl(input int idx);
    logic [1:0] up_seq [4];
    up_seq[0] = 2'b00; up_seq[1] = 2'b01; up_seq[2] = 2'b11; up_seq[3] = 2'b10;
    return up_seq[idx % 4];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called right after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input logic [1:0] nxt);
    int d;
    d = (seq_idx(nxt) - seq_idx(cur_lvl) + 4) % 4;
    {a_in, b_in} = nxt;
    if (d == 1) step_q.push_back('{due: cyc + LAT, val: 2'b01});
    else if (d == 3) step_q.push_back('{due: cyc + LAT, val: 2'b00});
    else if (d == 2) begin
      if (!err_final) begin
        err_q.push_back('{due: cyc + LAT, val: 2'b01});
        err_final = 1'b1;
      end
      last_ill_due = cyc + LAT;
    end
    if (d != 0) ab_q.push_back('{due: cyc + ALAT, val: nxt});
    cur_lvl = nxt;
  endtask

  task automatic glitch(input logic [1:0] mask, input int len);
    {a_in, b_in} = cur_lvl ^ mask;
    idle(len);
    {a_in, b_in} = cur_lvl;
  endtask

  // One-cycle clear. It takes effect at the next rising edge, unless an
  // illegal decode falls on that same edge.
  task automatic pulse_clr();
    clr_err = 1'b1;
    if (last_ill_due != cyc + 1 && err_final) begin
      err_q.push_back('{due: cyc + 1, val: 2'b00});
      err_final = 1'b0;
    end
    idle(1);
    clr_err = 1'b0;
  endtask

  task automatic flush_model();
    step_q.delete();
    err_q.delete();
    ab_q.delete();
    err_final    = 1'b0;
    err_exp      = 1'b0;
    dir_exp      = 1'b0;
    chk_ab       = 1'b0;
    last_ill_due = -100;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    ev_t ev;
    if (rst === 1'b1) begin
      while (step_q.size() > 0 && step_q[0].due < cyc) begin
        ev = step_q.pop_front();
        check("step_missing_cycle", cyc, ev.due);
      end
      if (step === 1'b1) begin
        if (step_q.size() == 0) begin
          check("unexpected_step", step, 0);
        end else begin
          ev = step_q.pop_front();
          check("step_cycle", cyc, ev.due);
          dir_exp = ev.val[0];
        end
      end
      check("dir", dir, dir_exp);

      while (err_q.size() > 0 && err_q[0].due <= cyc) begin
        ev = err_q.pop_front();
        err_exp = ev.val[0];
      end
      check("err", err, err_exp);

      if (chk_ab) begin
        while (ab_q.size() > 0 && ab_q[0].due <= cyc) begin
          ev = ab_q.pop_front();
          ab_exp = ev.val;
        end
        check("ab_state", ab_state, ab_exp);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time bound at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    int r;
    int idx;
    rst     = 1'b0;
    clr_err = 1'b0;
    a_in    = 1'b1;
    b_in    = 1'b1;
    cur_lvl = 2'b11;
    ab_exp  = 2'b00;
    flush_model();

    idle(3);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_err", err, 0);
    check("rst_ab", ab_state, 2'b00);

    // 1: inputs parked at 11 through reset release.
    rst = 1'b1;
    idle(5);
    check("t1_ab_after_init", ab_state, 2'b11);
    check("t1_err", err, 0);
    ab_exp = 2'b11;
    chk_ab = 1'b1;
    idle(10);

    // 2: up walk, ending at 00 with each level held for 10 cycles.
    for (int i = 0; i < 6; i++) begin
      move(seq_lvl(seq_idx(cur_lvl) + 1));
      idle(10);
    end
    check("t2_dir", dir, 1);
    check("t2_ab", ab_state, 2'b00);

    // 3: down walk 00->10->11->01->00.
    for (int i = 0; i < 4; i++) begin
      move(seq_lvl(seq_idx(cur_lvl) + 3));
      idle(10);
    end
    check("t3_dir", dir, 0);
    check("t3_ab", ab_state, 2'b00);

    // 4: short pulses on A. The second pair checks that the filter count
    // restarts after a one-cycle return to the accepted level.
    glitch(2'b10, 2);
    idle(8);
    glitch(2'b10, 2);
    idle(1);
    glitch(2'b10, 2);
    idle(10);
    check("t4_ab", ab_state, 2'b00);
    check("t4_no_step_pending", step_q.size(), 0);

    // 5: double transitions and clearing.
    move(2'b11);
    idle(10);
    check("t5_err_set", err, 1);
    check("t5_dir_held", dir, 0);
    pulse_clr();
    idle(3);
    check("t5_err_cleared", err, 0);
    move(2'b00);
    idle(5);
    pulse_clr();  // lands on the same edge as the illegal decode
    idle(4);
    check("t5_set_beats_clear", err, 1);

    // 6: asynchronous reset in the middle of a walk.
    move(2'b01);
    idle(4);
    move(2'b11);
    idle(2);
    check("t6_step_before_rst", step, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_step_async", step, 0);
    check("t6_dir_async", dir, 0);
    check("t6_err_async", err, 0);
    check("t6_ab_async", ab_state, 2'b00);
    flush_model();
    idle(3);
    rst = 1'b1;
    idle(6);
    check("t6_ab_after_init", ab_state, cur_lvl);
    ab_exp = cur_lvl;
    chk_ab = 1'b1;
    for (int i = 0; i < 3; i++) begin
      move(seq_lvl(seq_idx(cur_lvl) + 1));
      idle(8);
    end
    check("t6_dir_up", dir, 1);
    check("t6_err_clean", err, 0);

    // Random traffic: neighbour moves, double moves, glitches and clears.
    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 9);
      idx = seq_idx(cur_lvl);
      if (r <= 5) begin
        move(seq_lvl(idx + (($urandom_range(0, 1) == 1) ? 1 : 3)));
        idle($urandom_range(4, 10));
      end else if (r == 6) begin
        move(cur_lvl ^ 2'b11);
        idle($urandom_range(4, 10));
      end else if (r == 7) begin
        glitch(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, $urandom_range(1, 2));
        idle($urandom_range(4, 8));
      end else if (r == 8) begin
        if (last_ill_due < cyc) pulse_clr();
        idle(1);
      end else begin
        idle($urandom_range(1, 6));
      end
    end

    idle(LAT + 6);
    check("drain_steps", step_q.size(), 0);
    check("drain_err", err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_quad_step_decoder
